nnrv_wb: RTL and testbench

NNRV_WB -- requirements
Module: nnrv_wb

---
 rtl/nnrv_pkg.sv | 18 +
 rtl/nnrv_load_align.sv | 33 +++
 rtl/nnrv_wb.sv | 137 +++++++++++++
 tb/tb_nnrv_wb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnrv_pkg.sv
// nnrv_pkg -- shared definitions for the NNRV write-back slice.
//   - Load funct3 encodings (LB, LH, LW, LBU, LHU).
//   - Write-back FSM state type.
package nnrv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_COMMIT
    } wb_state_e;

endpackage

// File: rtl/nnrv_load_align.sv
// nnrv_load_align -- combinational load data extract/extend.
// Ports:
//   rdata   [XLEN-1:0] in   word-aligned memory read data
//   funct3  [2:0]      in   load type (unsupported encodings behave as LW)
//   addr_lo [1:0]      in   byte offset within the word
//   data    [XLEN-1:0] out  aligned, sign/zero-extended result
module nnrv_load_align
    import nnrv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/nnrv_wb.sv
// nnrv_wb -- write-back stage: commits ALU results and aligned load data to
// the register file, detecting misaligned loads at acceptance.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_valid / o_ready          upstream handshake (ready only in IDLE)
//   i_rd, i_rd_we, i_is_load, i_funct3, i_addr_lo, i_alu_res  instruction info
//   i_mem_valid, i_mem_rdata   load response
//   o_w_en, o_w, o_w_reg       register-file write port
//   o_misalign                 one-cycle pulse on a misaligned load
//   o_busy                     a load is outstanding
// Optional macro NNRV_WB_BYPASS_EN adds o_fwd_valid/o_fwd_rd/o_fwd_data, a
// same-cycle mirror of the write port for operand forwarding.
module nnrv_wb
    import nnrv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_we,
    input  logic            i_is_load,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_alu_res,
    input  logic            i_mem_valid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_w_en,
    output logic [4:0]      o_w,
    output logic [XLEN-1:0] o_w_reg,
    output logic            o_misalign,
    output logic            o_busy
`ifdef NNRV_WB_BYPASS_EN
    ,
    output logic            o_fwd_valid,
    output logic [4:0]      o_fwd_rd,
    output logic [XLEN-1:0] o_fwd_data
`endif
);

    wb_state_e       state, state_nx;
    logic            accept;
    logic            misaligned;
    logic [4:0]      rd_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      addr_q;
    logic [XLEN-1:0] ld_data;

    assign accept  = i_valid && (state == ST_IDLE);
    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state == ST_LOAD_WAIT);

    // Unsupported funct3 falls into the LW (word) alignment rule.
    always_comb begin
        case (i_funct3)
            F3_LB, F3_LBU: misaligned = 1'b0;
            F3_LH, F3_LHU: misaligned = i_addr_lo[0];
            default:       misaligned = |i_addr_lo;
        endcase
    end

    nnrv_load_align #(.XLEN(XLEN)) u_align (
        .rdata   (i_mem_rdata),
        .funct3  (f3_q),
        .addr_lo (addr_q),
        .data    (ld_data)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (accept && i_is_load && !misaligned) state_nx = ST_LOAD_WAIT;
            ST_LOAD_WAIT: if (i_mem_valid) state_nx = ST_COMMIT;
            ST_COMMIT:    state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_q   <= '0;
            we_q   <= 1'b0;
            f3_q   <= '0;
            addr_q <= '0;
        end else if (accept && i_is_load) begin
            rd_q   <= i_rd;
            we_q   <= i_rd_we;
            f3_q   <= i_funct3;
            addr_q <= i_addr_lo;
        end
    end

    // Write port registers: o_w/o_w_reg only change on a real write, so they
    // hold their last committed value otherwise. The load write enable is
    // raised on the mem_valid edge, i.e. it is high during COMMIT.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_w_en     <= 1'b0;
            o_w        <= '0;
            o_w_reg    <= '0;
            o_misalign <= 1'b0;
        end else begin
            o_w_en     <= 1'b0;
            o_misalign <= 1'b0;
            if (accept && !i_is_load) begin
                if (i_rd_we && (i_rd != 5'd0)) begin
                    o_w_en  <= 1'b1;
                    o_w     <= i_rd;
                    o_w_reg <= i_alu_res;
                end
            end else if (accept && i_is_load && misaligned) begin
                o_misalign <= 1'b1;
            end else if (state == ST_LOAD_WAIT && i_mem_valid) begin
                if (we_q && (rd_q != 5'd0)) begin
                    o_w_en  <= 1'b1;
                    o_w     <= rd_q;
                    o_w_reg <= ld_data;
                end
            end
        end
    end

`ifdef NNRV_WB_BYPASS_EN
    assign o_fwd_valid = o_w_en;
    assign o_fwd_rd    = o_w;
    assign o_fwd_data  = o_w_reg;
`endif

endmodule

// File: tb/tb_nnrv_wb.sv
module tb_nnrv_wb;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [4:0]      i_rd;
    logic            i_rd_we;
    logic            i_is_load;
    logic [2:0]      i_funct3;
    logic [1:0]      i_addr_lo;
    logic [XLEN-1:0] i_alu_res;
    logic            i_mem_valid;
    logic [XLEN-1:0] i_mem_rdata;
    logic            o_w_en;
    logic [4:0]      o_w;
    logic [XLEN-1:0] o_w_reg;
    logic            o_misalign;
    logic            o_busy;
`ifdef NNRV_WB_BYPASS_EN
    logic            o_fwd_valid;
    logic [4:0]      o_fwd_rd;
    logic [XLEN-1:0] o_fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model of the register-file write port's last committed value.
    logic [4:0]  m_w   = '0;
    logic [31:0] m_reg = '0;

    nnrv_wb #(.XLEN(XLEN)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_rd        (i_rd),
        .i_rd_we     (i_rd_we),
        .i_is_load   (i_is_load),
        .i_funct3    (i_funct3),
        .i_addr_lo   (i_addr_lo),
        .i_alu_res   (i_alu_res),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata),
        .o_w_en      (o_w_en),
        .o_w         (o_w),
        .o_w_reg     (o_w_reg),
        .o_misalign  (o_misalign),
        .o_busy      (o_busy)
`ifdef NNRV_WB_BYPASS_EN
        ,
        .o_fwd_valid (o_fwd_valid),
        .o_fwd_rd    (o_fwd_rd),
        .o_fwd_data  (o_fwd_data)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Access size in bytes and signedness derived from funct3.
    function automatic int unsigned ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (int'(a) % ref_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        longint unsigned m, v;
        bit sgn;
        sgn = (f3 == 3'b000) || (f3 == 3'b001);
        m = 64'd1 << (8 * ref_size(f3));
        v = (64'(d) >> (8 * int'(a))) % m;
        if (sgn && v >= m / 2) v = v + (64'd1 << 32) - m;
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        i_valid     = 1'b0;
        i_rd        = 5'($urandom);
        i_rd_we     = 1'($urandom);
        i_is_load   = 1'($urandom);
        i_funct3    = 3'($urandom);
        i_addr_lo   = 2'($urandom);
        i_alu_res   = $urandom;
        i_mem_valid = 1'b0;
        i_mem_rdata = $urandom;
    endtask

    // Drive one ALU op, advance one edge, check the write port.
    task automatic do_alu(input logic [4:0] rd, input logic we, input logic [31:0] val);
        bit exp_en;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL alu_ready: got %b want 1", o_ready);
        end
        i_valid = 1'b1; i_is_load = 1'b0; i_rd = rd; i_rd_we = we; i_alu_res = val;
        i_funct3 = 3'($urandom); i_addr_lo = 2'($urandom);
        i_mem_valid = 1'($urandom); i_mem_rdata = $urandom;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_valid = 1'b0;
        exp_en = we && (rd != 5'd0);
        if (exp_en) begin m_w = rd; m_reg = val; end
        n_cmp++;
        if (o_w_en !== exp_en || o_w !== m_w || o_w_reg !== m_reg) begin
            n_err++;
            $display("FAIL alu_write: got en=%b w=%0d reg=%h want en=%b w=%0d reg=%h",
                     o_w_en, o_w, o_w_reg, exp_en, m_w, m_reg);
        end
`ifdef NNRV_WB_BYPASS_EN
        n_cmp++;
        if (o_fwd_valid !== exp_en || o_fwd_rd !== m_w || o_fwd_data !== m_reg) begin
            n_err++;
            $display("FAIL alu_fwd: got v=%b rd=%0d d=%h want v=%b rd=%0d d=%h",
                     o_fwd_valid, o_fwd_rd, o_fwd_data, exp_en, m_w, m_reg);
        end
`endif
    endtask

    task automatic idle_cycle();
        idle_inputs();
        i_mem_valid = 1'($urandom);
        @(posedge i_clk); #1;
        i_mem_valid = 1'b0;
        n_cmp++;
        if (o_w_en !== 1'b0 || o_misalign !== 1'b0 || o_w !== m_w || o_w_reg !== m_reg
            || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle: got en=%b mis=%b w=%0d reg=%h rdy=%b want en=0 mis=0 w=%0d reg=%h rdy=1",
                     o_w_en, o_misalign, o_w, o_w_reg, o_ready, m_w, m_reg);
        end
    endtask

    // Drive one load; 'delay' cycles of LOAD_WAIT elapse before mem_valid.
    task automatic do_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                           input logic [1:0] a, input logic [31:0] d, input int delay);
        bit exp_en;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL load_ready: got %b want 1", o_ready);
        end
        i_valid = 1'b1; i_is_load = 1'b1; i_rd = rd; i_rd_we = we;
        i_funct3 = f3; i_addr_lo = a; i_alu_res = $urandom;
        @(posedge i_clk); #1;
        idle_inputs();
        if (ref_misaligned(f3, a)) begin
            n_cmp++;
            if (o_misalign !== 1'b1 || o_w_en !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL misalign: got mis=%b en=%b rdy=%b busy=%b want 1 0 1 0",
                         o_misalign, o_w_en, o_ready, o_busy);
            end
            idle_cycle();
            return;
        end
        n_cmp++;
        if (o_misalign !== 1'b0 || o_busy !== 1'b1 || o_ready !== 1'b0 || o_w_en !== 1'b0) begin
            n_err++;
            $display("FAIL load_accept: got mis=%b busy=%b rdy=%b en=%b want 0 1 0 0",
                     o_misalign, o_busy, o_ready, o_w_en);
        end
        for (int i = 0; i < delay; i++) begin
            i_valid = 1'($urandom);
            @(posedge i_clk); #1;
            n_cmp++;
            if (o_busy !== 1'b1 || o_ready !== 1'b0 || o_w_en !== 1'b0) begin
                n_err++;
                $display("FAIL load_wait: got busy=%b rdy=%b en=%b want 1 0 0",
                         o_busy, o_ready, o_w_en);
            end
        end
        i_valid = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = d;
        @(posedge i_clk); #1;
        idle_inputs();
        exp_en = we && (rd != 5'd0);
        if (exp_en) begin m_w = rd; m_reg = ref_load(f3, a, d); end
        n_cmp++;
        if (o_w_en !== exp_en || o_w !== m_w || o_w_reg !== m_reg
            || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_commit: got en=%b w=%0d reg=%h busy=%b rdy=%b want en=%b w=%0d reg=%h busy=0 rdy=0",
                     o_w_en, o_w, o_w_reg, o_busy, o_ready, exp_en, m_w, m_reg);
        end
        idle_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1'b0;
        #3;
        n_cmp++;
        if (o_w_en !== 1'b0 || o_misalign !== 1'b0 || o_busy !== 1'b0 || o_w !== 5'd0
            || o_w_reg !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: got en=%b mis=%b busy=%b w=%0d reg=%h want all 0",
                     o_w_en, o_misalign, o_busy, o_w, o_w_reg);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_alu();
        do_alu(5'd5, 1'b1, 32'h1234_5678);
        idle_cycle();
    endtask

    task automatic test_load();
        do_load(5'd7, 1'b1, 3'b000, 2'd3, 32'h80FF_FFFF, 3);
        do_load(5'd8, 1'b1, 3'b100, 2'd3, 32'h80FF_FFFF, 3);
        do_load(5'd9, 1'b1, 3'b001, 2'd2, 32'h9ABC_0000, 0);
        do_load(5'd10, 1'b1, 3'b101, 2'd2, 32'h9ABC_0000, 1);
        do_load(5'd11, 1'b1, 3'b010, 2'd0, 32'hDEAD_BEEF, 2);
        do_load(5'd12, 1'b1, 3'b111, 2'd0, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_misalign();
        do_load(5'd3, 1'b1, 3'b001, 2'd1, $urandom, 0);
        do_load(5'd3, 1'b1, 3'b101, 2'd3, $urandom, 0);
        do_load(5'd3, 1'b1, 3'b010, 2'd2, $urandom, 0);
        do_load(5'd3, 1'b1, 3'b011, 2'd1, $urandom, 0);
    endtask

    task automatic test_no_write();
        do_alu(5'd0, 1'b1, 32'hFFFF_FFFF);
        do_alu(5'd6, 1'b0, 32'h0BAD_0BAD);
        do_load(5'd4, 1'b0, 3'b010, 2'd0, 32'h1111_2222, 2);
        do_load(5'd0, 1'b1, 3'b000, 2'd1, 32'h3333_4444, 1);
    endtask

    task automatic test_reset_midload();
        i_valid = 1'b1; i_is_load = 1'b1; i_rd = 5'd13; i_rd_we = 1'b1;
        i_funct3 = 3'b010; i_addr_lo = 2'd0;
        @(posedge i_clk); #1;
        idle_inputs();
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        #1;
        m_w = '0; m_reg = '0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_w_en !== 1'b0 || o_w !== 5'd0 || o_w_reg !== 32'd0
            || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midload_reset: got busy=%b en=%b w=%0d reg=%h rdy=%b want 0 0 0 0 1",
                     o_busy, o_w_en, o_w, o_w_reg, o_ready);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        i_mem_valid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
        @(posedge i_clk); #1;
        i_mem_valid = 1'b0;
        n_cmp++;
        if (o_w_en !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_w_reg !== 32'd0) begin
            n_err++;
            $display("FAIL midload_after: got en=%b busy=%b rdy=%b reg=%h want 0 0 1 0",
                     o_w_en, o_busy, o_ready, o_w_reg);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_alu(5'(i + 1), 1'b1, $urandom);
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(1, 0) == 0)
                do_alu(5'($urandom), 1'($urandom), $urandom);
            else
                do_load(5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
                        $urandom, int'($urandom_range(4, 0)));
            if ($urandom_range(3, 0) == 0) idle_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_misalign();
        test_no_write();
        test_reset_midload();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
